pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised valid/ready pipeline stage register replacing fixed-field stall/flush registers between qtpa pipeline stages (first user: ISSUE→EXECUTE). It carries an opaque `WIDTH`-bit payload, decouples upstream and downstream with a two-entry skid buffer, and supports full-throughput streaming, back-pressure without combinational ready paths, and synchronous flush. Bubbles are explicit: `out_valid` low means no instruction; when empty, the payload is forced to `EMPTY_VAL`.

## Interface
- `WIDTH`, 32: payload width in bits.
- `EMPTY_VAL`, `'0`: payload value presented whenever the stage is empty, after reset and after flush. ISSUE→EXECUTE instances set it to the packed NOP packet.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high; clock clk.
- `flush` in 1: kills all held entries; synchronous.
- `in_valid` in 1: upstream has a payload.
- `in_ready` out 1: stage can accept; registered.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: `out_data` holds a live payload.
- `out_ready` in 1: downstream consumes this cycle.
- `out_data` out WIDTH: payload, driven from the main register.
- `occupancy` out 2: entries held, 0..2, for the hazard unit and perf counters.

## Operation
- Definitions: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main register (`main_q`, `main_v`) and skid register (`skid_q`, `skid_v`).
- State is encoded by occupancy: EMPTY (0), ONE (1), FULL (2).
- EMPTY: `in_fire` → ONE with `main_q <= in_data`. Otherwise stays EMPTY.
- ONE:
  - `in_fire & out_fire` → ONE with `main_q <= in_data`.
  - `out_fire` only → EMPTY.
  - `in_fire` only → FULL with `skid_q <= in_data`.
  - Neither → ONE, hold.
- FULL: `in_ready` is 0, so no accept occurs. `out_fire` → ONE with `main_q <= skid_q`. Otherwise FULL, hold.
- Outputs:
  - `in_ready = !skid_v`, from a flop.
  - `out_valid = main_v`.
  - `occupancy = main_v + skid_v`.
- Priority: `rst` > `flush` > handshake.
- Flush:
  - All valids clear and both data registers load `EMPTY_VAL`.
  - An `in_fire` in the same cycle is discarded.
  - An `out_fire` in the same cycle still counts as consumed downstream.
- Order is strictly FIFO: skid data is never presented ahead of main data.
- Data registers are written only on the transitions above; they never change while held.
- `in_valid` may deassert at any time. `in_data` is sampled only on `in_fire`.

## Timing
- Reset values: `out_valid=0`, `out_data=EMPTY_VAL`, `in_ready=1`, `occupancy=0`; skid register = `EMPTY_VAL`.
- Latency: a payload accepted on edge N is presented with `out_valid=1` after edge N, i.e. in cycle N+1.
- Throughput: 1 payload/cycle sustained while `out_ready=1`.
- Back-pressure: `out_ready` falls in cycle K. At most one further payload is absorbed (into skid), and `in_ready` falls after edge K.
- Release: `out_ready` rises in FULL. `in_ready` returns to 1 one cycle later; no payload is lost or duplicated.
- Combinational paths: none from `out_ready` to `in_ready`, and none from `in_*` to `out_*`.
- Reset or flush mid-FULL: the stage is EMPTY the next cycle with `in_ready=1`.

## Structure
- Add `typedef struct packed` `iss_ex_pkt_t` to `qtpa_pkg`. Fields: `alu_op`, `rd_addr`, `we`, `imm_ext`, `use_imm`, `rs1_data`, `rs2_data`, `rs1_addr`, `rs2_addr`.
- Add `ISS_EX_NOP_PKT` to `qtpa_pkg`, with `alu_op=NOP` and all other fields 0. Instances use `WIDTH=$bits(iss_ex_pkt_t)`.
- The block is a single module with no sub-modules. Register update uses one `always_ff`, driven by a small `always_comb` next-state decode.
- The legacy `stall` maps to `out_ready=!stall` at the instantiation site.

## Test plan
- Reset, then idle: `out_valid=0`, `out_data=EMPTY_VAL`, `in_ready=1`, `occupancy=0` for 10 cycles.
- Stream 0x11..0x18 with `out_ready=1`: outputs 0x11..0x18 on consecutive cycles, each one cycle after acceptance, with `occupancy` constant at 1.
- Stream 0xA0, 0xA1, 0xA2 with `out_ready` dropped the cycle after 0xA0 is presented:
  - `occupancy` reaches 2 and `in_ready` goes 0.
  - 0xA2 is held upstream.
  - Raising `out_ready` yields 0xA0, 0xA1, 0xA2 in order.
- FULL with payloads 0x5, 0x6, then `flush=1` with `in_valid=1` and `in_data=0x7`: next cycle `out_valid=0`, `out_data=EMPTY_VAL`, `in_ready=1`, and 0x7 never appears.
- Random `in_valid`/`out_ready` (50%, 10k cycles) against a scoreboard queue: no loss, duplication or reordering; `occupancy` ≤ 2; `in_ready` equals `!(occupancy==2)` delayed correctly.
- `rst` asserted mid-stream in FULL: next cycle all outputs are at their reset values, and the stream resumes cleanly afterwards.

Source files
------------

// File: rtl/qtpa_pkg.sv
// Shared qtpa pipeline types: elastic stage occupancy encoding and the ISSUE->EXECUTE packet.
package qtpa_pkg;

    localparam int unsigned OCC_W      = 2;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [OCC_W-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e               alu_op;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  we;
        logic [XLEN-1:0]       imm_ext;
        logic                  use_imm;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
    } iss_ex_pkt_t;

    localparam iss_ex_pkt_t ISS_EX_NOP_PKT = '{
        alu_op:   ALU_NOP,
        rd_addr:  '0,
        we:       1'b0,
        imm_ext:  '0,
        use_imm:  1'b0,
        rs1_data: '0,
        rs2_data: '0,
        rs1_addr: '0,
        rs2_addr: '0
    };

endpackage

// File: rtl/pipe_stage_elastic.sv
// Valid/ready pipeline register with a two-entry skid buffer; in_ready is a flop so
// no combinational path runs from out_ready back upstream.
module pipe_stage_elastic
    import qtpa_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic             in_ready_q, in_ready_d;
    occ_e             occ_q, occ_d;
    logic             in_fire;
    logic             out_fire;

    // Next-state decode; occupancy doubles as the state register.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        occ_d    = occ_q;
        in_fire  = in_valid & in_ready_q;
        out_fire = main_v_q & out_ready;

        if (flush) begin
            main_d   = EMPTY_VAL;
            skid_d   = EMPTY_VAL;
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            occ_d    = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_d   = in_data;
                        main_v_d = 1'b1;
                        occ_d    = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        main_d   = EMPTY_VAL;
                        main_v_d = 1'b0;
                        occ_d    = OCC_EMPTY;
                    end else if (in_fire) begin
                        skid_d   = in_data;
                        skid_v_d = 1'b1;
                        occ_d    = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    // Skid drains into main so order stays FIFO.
                    if (out_fire) begin
                        main_d   = skid_q;
                        skid_d   = EMPTY_VAL;
                        skid_v_d = 1'b0;
                        occ_d    = OCC_ONE;
                    end
                end
                default: begin
                    main_d   = EMPTY_VAL;
                    skid_d   = EMPTY_VAL;
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                    occ_d    = OCC_EMPTY;
                end
            endcase
        end

        in_ready_d = ~skid_v_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= EMPTY_VAL;
            skid_q     <= EMPTY_VAL;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            occ_q      <= OCC_EMPTY;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;
    assign occupancy = OCC_W'(occ_q);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a queue model checked every cycle plus directed
// literal expectations for streaming, back-pressure, flush and reset.
module tb_pipe_stage_elastic;

    localparam int unsigned W  = 32;
    localparam logic [W-1:0] EV = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;
    int model_pops = 0;
    int dut_pops = 0;

    logic [W-1:0] mq[$];   // model contents, head = presented payload
    logic [W-1:0] got[$];  // payloads the DUT handed downstream

    pipe_stage_elastic #(.WIDTH(W), .EMPTY_VAL(EV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compare DUT outputs with the queue model.
    task automatic cmp_model();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("out_data", out_data, (mq.size() > 0) ? mq[0] : EV);
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
        bit inf, outf;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        if (out_valid && ordy && !r) begin
            got.push_back(out_data);
            dut_pops++;
        end
        outf = (mq.size() > 0) && ordy;
        inf  = iv && (mq.size() < 2);
        @(posedge clk);
        if (outf && !r) model_pops++;
        if (r || f) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(d);
        end
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'hDEAD_BEEF);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);

        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 32'h0, 1'b0);
        chk("idle_out_data", out_data, 32'hDEAD_BEEF);

        // Full-rate stream
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 32'h11 + 32'(i), 1);
            chk("stream_occ", 32'(occupancy), 32'd1);
            chk("stream_data", out_data, 32'h11 + 32'(i));
        end
        cyc(0, 0, 0, 0, 1);
        chk("stream_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("stream_order", got[i], 32'h11 + 32'(i));

        // Back-pressure
        got.delete();
        cyc(0, 0, 1, 32'hA0, 1);
        chk("bp_a0_shown", out_data, 32'hA0);
        cyc(0, 0, 1, 32'hA1, 0);
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready0", 32'(in_ready), 32'd0);
        cyc(0, 0, 1, 32'hA2, 0);
        chk("bp_hold_data", out_data, 32'hA0);
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        cyc(0, 0, 1, 32'hA2, 1);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        cyc(0, 0, 1, 32'hA2, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("bp_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_0", got[0], 32'hA0);
            chk("bp_1", got[1], 32'hA1);
            chk("bp_2", got[2], 32'hA2);
        end

        // Flush from FULL with a concurrent accept attempt
        cyc(0, 0, 1, 32'h5, 0);
        cyc(0, 0, 1, 32'h6, 0);
        chk("fl_full", 32'(occupancy), 32'd2);
        got.delete();
        cyc(0, 1, 1, 32'h7, 0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_out_data", out_data, 32'hDEAD_BEEF);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_occ", 32'(occupancy), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk("fl_no7", 32'(got.size()), 32'd0);

        // Random traffic against the model
        model_pops = 0; dut_pops = 0;
        for (int i = 0; i < 10000; i++)
            cyc(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        chk("rand_pops", 32'(dut_pops), 32'(model_pops));

        // Reset while FULL, then resume
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 32'h31, 0);
        cyc(0, 0, 1, 32'h32, 0);
        chk("rs_full", 32'(occupancy), 32'd2);
        cyc(1, 0, 1, 32'h33, 1);
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_out_data", out_data, 32'hDEAD_BEEF);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        chk("rs_occ", 32'(occupancy), 32'd0);
        got.delete();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h41 + 32'(i), 1);
        cyc(0, 0, 0, 0, 1);
        chk("rs_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk("rs_order", got[i], 32'h41 + 32'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
